// File: rtl/offset_accum_adder_pkg.sv
// Shared arithmetic definitions for the lab datapath.
// Mode encodings used by the offset/accumulator adder.
package lab_arith_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_OFS = 2'b00,
        MODE_ACC     = 2'b01,
        MODE_ACC_OFS = 2'b10,
        MODE_CLEAR   = 2'b11
    } mode_e;

endpackage

// File: rtl/offset_accum_adder_if.sv
// Operand and result handshake bundle for offset_accum_adder.
// master drives operands and consumes results; slave is the adder.
interface offset_accum_adder_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  input_a;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;
    logic             ovf;
    logic             ovf_sticky;

    modport master (
        output in_valid, input_a, mode, out_ready,
        input  in_ready, out_valid, result, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, input_a, mode, out_ready,
        output in_ready, out_valid, result, ovf, ovf_sticky
    );
endinterface

// File: rtl/offset_accum_adder_sat_add.sv
// Reduces a widened raw sum to W bits with wrap or clamp.
// o flags any raw sum above the W-bit maximum.
module sat_add #(
    parameter int W        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic [W+1:0] r_i,
    output logic [W-1:0] val_o,
    output logic         o_o
);
    assign o_o = |r_i[W+1:W];

    generate
        if (SATURATE) begin : g_sat
            assign val_o = o_o ? {W{1'b1}} : r_i[W-1:0];
        end else begin : g_wrap
            assign val_o = r_i[W-1:0];
        end
    endgenerate
endmodule

// File: rtl/offset_accum_adder.sv
// Registered offset/accumulator adder with one-entry output stage.
// Overflow is wrapped or clamped, and tracked in a sticky flag.
module offset_accum_adder
    import lab_arith_pkg::*;
#(
    parameter int IN_W     = 2,
    parameter int OUT_W    = 4,
    parameter int OFFSET   = 7,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    offset_accum_adder_if.slave   bus
);
    localparam int RW = OUT_W + 2;

    generate
        if (IN_W > OUT_W) begin : g_bad_w
            $error("offset_accum_adder: IN_W must not exceed OUT_W");
        end
        if (OFFSET < 0 || OFFSET > (2 ** OUT_W) - 1) begin : g_bad_ofs
            $error("offset_accum_adder: OFFSET out of range");
        end
    endgenerate

    localparam logic [RW-1:0] OFS = RW'(OFFSET);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    logic             accept;
    mode_e            mode;
    logic [RW-1:0]    r;
    logic [RW-1:0]    a_x;
    logic [RW-1:0]    acc_x;
    logic [OUT_W-1:0] val;
    logic             o;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mode         = mode_e'(bus.mode);
    assign a_x          = RW'(bus.input_a);
    assign acc_x        = RW'(acc_q);

    // Raw widened sum selected by the operation mode.
    always_comb begin
        r = '0;
        case (mode)
            MODE_ADD_OFS: r = a_x + OFS;
            MODE_ACC:     r = acc_x + a_x;
            MODE_ACC_OFS: r = acc_x + a_x + OFS;
            MODE_CLEAR:   r = '0;
            default:      r = '0;
        endcase
    end

    sat_add #(
        .W        (OUT_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .r_i   (r),
        .val_o (val),
        .o_o   (o)
    );

    // Next state: load on accept, drain on consume, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;
        acc_d       = acc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = val;
            ovf_d       = o;
            sticky_d    = (mode == MODE_CLEAR) ? 1'b0 : (sticky_q | o);
            if (mode != MODE_ADD_OFS) begin
                acc_d = val;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending result and the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_offset_accum_adder.sv
// Directed bench for offset_accum_adder, wrap and saturate builds.
// Expected values are hand-computed for IN_W=2, OUT_W=4, OFFSET=7.
module tb_offset_accum_adder;
    import lab_arith_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    offset_accum_adder_if #(.IN_W(2), .OUT_W(4)) bw ();
    offset_accum_adder_if #(.IN_W(2), .OUT_W(4)) bs ();

    offset_accum_adder #(
        .IN_W(2), .OUT_W(4), .OFFSET(7), .SATURATE(1'b0)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    offset_accum_adder #(
        .IN_W(2), .OUT_W(4), .OFFSET(7), .SATURATE(1'b1)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_w(input logic v, input logic [1:0] m,
                           input logic [1:0] a);
        bw.in_valid = v;
        bw.mode     = m;
        bw.input_a  = a;
    endtask

    task automatic drive_s(input logic v, input logic [1:0] m,
                           input logic [1:0] a);
        bs.in_valid = v;
        bs.mode     = m;
        bs.input_a  = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [3:0] res,
                         input logic ov, input logic st);
        chk({tag, ".valid"}, 32'(bw.out_valid), 32'd1);
        chk({tag, ".result"}, 32'(bw.result), 32'(res));
        chk({tag, ".ovf"}, 32'(bw.ovf), 32'(ov));
        chk({tag, ".sticky"}, 32'(bw.ovf_sticky), 32'(st));
    endtask

    task automatic chk_s(input string tag, input logic [3:0] res,
                         input logic ov, input logic st);
        chk({tag, ".valid"}, 32'(bs.out_valid), 32'd1);
        chk({tag, ".result"}, 32'(bs.result), 32'(res));
        chk({tag, ".ovf"}, 32'(bs.ovf), 32'(ov));
        chk({tag, ".sticky"}, 32'(bs.ovf_sticky), 32'(st));
    endtask

    initial begin
        drive_w(1'b0, MODE_ADD_OFS, 2'd0);
        drive_s(1'b0, MODE_ADD_OFS, 2'd0);
        bw.out_ready = 1'b1;
        bs.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bw.out_valid), 32'd0);
        chk("rst.result", 32'(bw.result), 32'd0);
        chk("rst.ovf", 32'(bw.ovf), 32'd0);
        chk("rst.sticky", 32'(bw.ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(bw.in_ready), 32'd1);

        // ADD_OFS leaves acc alone
        drive_w(1'b1, MODE_ADD_OFS, 2'd3);
        tick();
        chk_w("addofs", 4'd10, 1'b0, 1'b0);
        drive_w(1'b1, MODE_ACC, 2'd1);
        tick();
        chk_w("acc_after_addofs", 4'd1, 1'b0, 1'b0);
        drive_w(1'b1, MODE_CLEAR, 2'd0);
        tick();
        chk_w("clear0", 4'd0, 1'b0, 1'b0);

        // Back-to-back ACC 3 with wrap on sixth
        drive_w(1'b1, MODE_ACC, 2'd3);
        tick(); chk_w("acc3_1", 4'd3, 1'b0, 1'b0);
        tick(); chk_w("acc3_2", 4'd6, 1'b0, 1'b0);
        tick(); chk_w("acc3_3", 4'd9, 1'b0, 1'b0);
        tick(); chk_w("acc3_4", 4'd12, 1'b0, 1'b0);
        tick(); chk_w("acc3_5", 4'd15, 1'b0, 1'b0);
        tick(); chk_w("acc3_6", 4'd2, 1'b1, 1'b1);

        // Drain, then backpressure
        drive_w(1'b0, MODE_ACC, 2'd0);
        tick();
        chk("drain.valid", 32'(bw.out_valid), 32'd0);
        chk("drain.result", 32'(bw.result), 32'd2);
        bw.out_ready = 1'b0;
        drive_w(1'b1, MODE_ACC, 2'd1);
        tick();
        chk_w("bp_first", 4'd3, 1'b0, 1'b1);
        chk("bp.in_ready", 32'(bw.in_ready), 32'd0);
        tick();
        chk_w("bp_hold1", 4'd3, 1'b0, 1'b1);
        tick();
        chk_w("bp_hold2", 4'd3, 1'b0, 1'b1);
        chk("bp.in_ready2", 32'(bw.in_ready), 32'd0);
        bw.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_rise", 32'(bw.in_ready), 32'd1);
        tick();
        chk_w("bp_release", 4'd4, 1'b0, 1'b1);

        // CLEAR after overflow wipes sticky
        drive_w(1'b1, MODE_CLEAR, 2'd0);
        tick();
        chk_w("clear", 4'd0, 1'b0, 1'b0);
        drive_w(1'b1, MODE_ACC, 2'd2);
        tick();
        chk_w("acc_after_clear", 4'd2, 1'b0, 1'b0);

        // Build acc=9 with a wrap on the way
        drive_w(1'b1, MODE_ACC_OFS, 2'd3);
        tick(); chk_w("accofs_1", 4'd12, 1'b0, 1'b0);
        tick(); chk_w("accofs_2", 4'd6, 1'b1, 1'b1);
        drive_w(1'b1, MODE_ACC, 2'd3);
        tick(); chk_w("to9", 4'd9, 1'b0, 1'b1);

        // Async reset between edges
        drive_w(1'b0, MODE_ACC, 2'd0);
        bw.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(bw.out_valid), 32'd0);
        chk("arst.result", 32'(bw.result), 32'd0);
        chk("arst.ovf", 32'(bw.ovf), 32'd0);
        chk("arst.sticky", 32'(bw.ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bw.out_ready = 1'b1;
        drive_w(1'b1, MODE_ACC, 2'd1);
        tick();
        chk_w("post_arst", 4'd1, 1'b0, 1'b0);
        drive_w(1'b0, MODE_ACC, 2'd0);

        // Saturating build
        drive_s(1'b1, MODE_ADD_OFS, 2'd3);
        tick(); chk_s("s_addofs", 4'd10, 1'b0, 1'b0);
        drive_s(1'b1, MODE_ACC_OFS, 2'd3);
        tick(); chk_s("s_accofs_1", 4'd10, 1'b0, 1'b0);
        tick(); chk_s("s_accofs_2", 4'd15, 1'b1, 1'b1);
        drive_s(1'b1, MODE_ACC, 2'd0);
        tick(); chk_s("s_acc0", 4'd15, 1'b0, 1'b1);
        drive_s(1'b1, MODE_ACC, 2'd3);
        tick(); chk_s("s_acc3", 4'd15, 1'b1, 1'b1);
        drive_s(1'b1, MODE_CLEAR, 2'd0);
        tick(); chk_s("s_clear", 4'd0, 1'b0, 1'b0);
        drive_s(1'b0, MODE_ACC, 2'd0);
        tick();
        chk("s_drain.valid", 32'(bs.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/offset_accum_adder.md
# offset_accum_adder

Parametrised, registered successor to the lab's 2-bit constant-offset adder. It adds an unsigned operand to a fixed offset, to a running accumulator, or to both. Each result goes through a one-entry valid/ready output stage with wrap or saturate overflow handling and a sticky overflow flag. It sits between the switch/input sampling logic and the LED/7-segment display driver in the lab top level.

## Interface
- IN_W, 2: operand width in bits.
- OUT_W, 4: result and accumulator width; IN_W <= OUT_W required.
- OFFSET, 7: constant added in offset modes; 0 <= OFFSET <= 2^OUT_W-1.
- SATURATE, 0: 0 = wrap on overflow, 1 = clamp to 2^OUT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/mode valid.
- in_ready  out  1  block can accept this cycle.
- input_a  in  IN_W  unsigned operand.
- mode  in  2  operation select: 00 ADD_OFS, 01 ACC, 10 ACC_OFS, 11 CLEAR.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes result this cycle.
- result  out  OUT_W  registered result.
- ovf  out  1  overflow of the operation that produced the current result.
- ovf_sticky  out  1  set by any overflow; cleared only by CLEAR or rst.

## Operation
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready, combinational, with no dependence on in_valid.
- On accept, raw sum is computed at OUT_W+2 bits, with all terms zero-extended:
  - ADD_OFS: r = input_a + OFFSET. Accumulator is unchanged.
  - ACC: r = acc + input_a.
  - ACC_OFS: r = acc + input_a + OFFSET.
  - CLEAR: r = 0, acc = 0, ovf = 0, ovf_sticky = 0. A result of 0 is still emitted with out_valid.
- Overflow o = (r > 2^OUT_W-1).
  - SATURATE=0: stored value = r[OUT_W-1:0].
  - SATURATE=1: stored value = o ? all-ones : r[OUT_W-1:0].
- result <= stored value; ovf <= o; ovf_sticky <= ovf_sticky | o (except CLEAR). ACC and ACC_OFS write acc <= stored value, so a saturated accumulator stays clamped.
- Output stage:
  - out_valid sets on accept.
  - out_valid clears when out_ready && !accept.
  - out_valid stays 1 on a simultaneous consume and accept (the new result replaces the old).
- When out_valid && !out_ready, the result register and acc hold. in_valid, input_a and mode are ignored.
- No accept → result, ovf, acc and ovf_sticky hold.

## Timing
- Reset values (async assert): out_valid=0, result=0, ovf=0, ovf_sticky=0, acc=0. in_ready=1 as soon as rst deasserts.
- Latency: 1 cycle from accept edge to out_valid/result.
- Throughput: 1 result/cycle while out_ready=1.
- Reset mid-operation discards the pending result and the accumulator, with no partial update. The first accept after deassertion behaves as from reset.
- Wrap example: OUT_W=4, acc=15, ACC in=3 → result=2, ovf=1.
- Inputs are sampled only on the accept edge. The consumer must treat result as valid only while out_valid=1.

## Structure
- Shared package lab_arith_pkg holds the mode encodings: MODE_ADD_OFS=2'b00, MODE_ACC=2'b01, MODE_ACC_OFS=2'b10, MODE_CLEAR=2'b11.
- One combinational sub-module, sat_add. It is parametrised by width and SATURATE and returns the stored value and o from r. The control/register logic stays in offset_accum_adder.
- Elaboration-time checks: IN_W <= OUT_W; OFFSET range as above.

## Test plan
Defaults IN_W=2, OUT_W=4, OFFSET=7 unless stated.
- ADD_OFS, input_a=3, out_ready=1 → next cycle out_valid=1, result=10, ovf=0. A following ACC in=1 gives result=1, showing acc was untouched.
- ACC in=3 ×6 back-to-back, out_ready=1 → results 3, 6, 9, 12, 15, 2. ovf=1 only on the last result; ovf_sticky=1 after it.
- SATURATE=1, ACC_OFS in=3 twice → result 10 (ovf=0), then 15 (ovf=1). A further ACC in=0 → 15, ovf=0.
- out_ready=0 after one accept → in_ready=0, result stays stable with in_valid held. Raising out_ready accepts the next operand in the same cycle, and the new result appears one cycle later.
- After an overflow, CLEAR → result=0, ovf=0, ovf_sticky=0. Then ACC in=2 → result=2.
- Assert rst asynchronously between clock edges while out_valid=1 and acc=9 → all outputs are 0 immediately. After release, ACC in=1 → result=1.
